// File: rtl/sc64_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sc64 (package)
//  Description : Shared types and default timing constants for the N64
//                reset/NMI transmit logic. Cycle counts assume a 100 MHz clock.
//  Revision    : 1.0 - initial release
// ============================================================================
package sc64;

    // Reset driver sequencing states
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SOFT_NMI   = 3'd1,
        HARD_NMI   = 3'd2,
        HARD_RESET = 3'd3,
        COOLDOWN   = 3'd4
    } reset_driver_state_e;

    // Default timings in system clock cycles (100 MHz)
    localparam int unsigned c_nmi_pulse_cycles    = 100000;    // 1 ms
    localparam int unsigned c_nmi_to_reset_cycles = 50000000;  // 500 ms
    localparam int unsigned c_reset_hold_cycles   = 10000000;  // 100 ms
    localparam int unsigned c_cooldown_cycles     = 1000000;   // 10 ms

    // Largest of four cycle counts; sizes the shared down-counter
    function automatic int unsigned max4(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c,
        input int unsigned d
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage : sc64
`default_nettype wire

// File: rtl/n64_reset_driver.sv
`default_nettype none
// ============================================================================
//  Module      : n64_reset_driver
//  Description : Sequences the N64 cartridge-edge NMI and RESET open-drain
//                enables from internal soft/hard reset requests. Soft reset
//                pulses NMI only; hard reset asserts NMI, then RESET, and
//                releases both together, followed by a request lockout.
//  Revision    : 1.0 - initial release
// ============================================================================
module n64_reset_driver
    import sc64::*;
#(
    parameter int unsigned NMI_PULSE_CYCLES    = c_nmi_pulse_cycles,
    parameter int unsigned NMI_TO_RESET_CYCLES = c_nmi_to_reset_cycles,
    parameter int unsigned RESET_HOLD_CYCLES   = c_reset_hold_cycles,
    parameter int unsigned COOLDOWN_CYCLES     = c_cooldown_cycles,
    parameter int unsigned CNT_W               = $clog2(max4(NMI_PULSE_CYCLES,
                                                             NMI_TO_RESET_CYCLES,
                                                             RESET_HOLD_CYCLES,
                                                             COOLDOWN_CYCLES)) + 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic soft_req,
    input  logic hard_req,
    input  logic ext_hard_reset,
    output logic req_ack,
    output logic busy,
    output logic done,
    output logic nmi_oe,
    output logic reset_oe
);

    // Elaboration-time sanity checks on the timing parameters
    if (NMI_PULSE_CYCLES < 1) begin : g_chk_nmi_pulse
        $error("NMI_PULSE_CYCLES must be >= 1");
    end
    if (NMI_TO_RESET_CYCLES < 1) begin : g_chk_nmi_to_reset
        $error("NMI_TO_RESET_CYCLES must be >= 1");
    end
    if (RESET_HOLD_CYCLES < 1) begin : g_chk_reset_hold
        $error("RESET_HOLD_CYCLES must be >= 1");
    end
    if (COOLDOWN_CYCLES < 1) begin : g_chk_cooldown
        $error("COOLDOWN_CYCLES must be >= 1");
    end
    if (CNT_W < $clog2(max4(NMI_PULSE_CYCLES, NMI_TO_RESET_CYCLES,
                            RESET_HOLD_CYCLES, COOLDOWN_CYCLES)) + 1) begin : g_chk_cnt_w
        $error("CNT_W too narrow for the configured cycle counts");
    end

    // Counter reload values: a phase of N cycles counts N-1 down to 0
    localparam logic [CNT_W-1:0] c_soft_load     = CNT_W'(NMI_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_hard_nmi_load = CNT_W'(NMI_TO_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_rst_hold_load = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cool_load     = CNT_W'(COOLDOWN_CYCLES - 1);

    reset_driver_state_e r_state;
    logic [CNT_W-1:0]    r_count;
    logic                w_count_zero;

    assign w_count_zero = (r_count == '0);

    // Sequencer FSM with shared down-counter; pin enables follow the state one edge later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_count  <= '0;
            req_ack  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            nmi_oe   <= 1'b0;
            reset_oe <= 1'b0;
        end else begin
            req_ack  <= 1'b0;
            done     <= 1'b0;
            // Enables track the state held during the previous cycle, so an
            // upgrade from SOFT_NMI to HARD_NMI keeps NMI driven without a gap
            nmi_oe   <= (r_state == SOFT_NMI) || (r_state == HARD_NMI) ||
                        (r_state == HARD_RESET);
            reset_oe <= (r_state == HARD_RESET);

            case (r_state)
                IDLE: begin
                    // Console already held in reset externally: ignore requests
                    if (!ext_hard_reset) begin
                        if (hard_req) begin
                            r_state <= HARD_NMI;
                            r_count <= c_hard_nmi_load;
                            req_ack <= 1'b1;
                            busy    <= 1'b1;
                        end else if (soft_req) begin
                            r_state <= SOFT_NMI;
                            r_count <= c_soft_load;
                            req_ack <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                end

                SOFT_NMI: begin
                    // A hard request upgrades an in-flight soft pulse
                    if (hard_req) begin
                        r_state <= HARD_NMI;
                        r_count <= c_hard_nmi_load;
                        req_ack <= 1'b1;
                    end else if (w_count_zero) begin
                        r_state <= COOLDOWN;
                        r_count <= c_cool_load;
                        done    <= 1'b1;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end

                HARD_NMI: begin
                    if (w_count_zero) begin
                        r_state <= HARD_RESET;
                        r_count <= c_rst_hold_load;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end

                HARD_RESET: begin
                    if (w_count_zero) begin
                        r_state <= COOLDOWN;
                        r_count <= c_cool_load;
                        done    <= 1'b1;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end

                COOLDOWN: begin
                    if (w_count_zero) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : n64_reset_driver
`default_nettype wire

// File: tb/tb_n64_reset_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_n64_reset_driver
//  Description : Self-checking bench for n64_reset_driver. A timeline model
//                predicts, from each accepted request, the cycle windows in
//                which every output must be high.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_n64_reset_driver;

    localparam int NP = 4;   // NMI pulse
    localparam int NR = 10;  // NMI to RESET
    localparam int RH = 6;   // RESET hold
    localparam int CD = 3;   // cooldown
    localparam int NONE = -1000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic soft_req = 1'b0;
    logic hard_req = 1'b0;
    logic ext_hard_reset = 1'b0;
    logic req_ack, busy, done, nmi_oe, reset_oe;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Timeline of the sequence in progress (cycle indices, inclusive)
    int ack_cyc, busy_from, busy_to, nmi_from, nmi_to, rst_from, rst_to, done_at, soft_last;

    n64_reset_driver #(
        .NMI_PULSE_CYCLES    (NP),
        .NMI_TO_RESET_CYCLES (NR),
        .RESET_HOLD_CYCLES   (RH),
        .COOLDOWN_CYCLES     (CD)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .soft_req       (soft_req),
        .hard_req       (hard_req),
        .ext_hard_reset (ext_hard_reset),
        .req_ack        (req_ack),
        .busy           (busy),
        .done           (done),
        .nmi_oe         (nmi_oe),
        .reset_oe       (reset_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        ack_cyc = NONE; busy_from = NONE; busy_to = NONE;
        nmi_from = NONE; nmi_to = NONE; rst_from = NONE; rst_to = NONE;
        done_at = NONE; soft_last = NONE;
    endtask

    // Soft pulse accepted at edge e
    task automatic start_soft(input int e);
        ack_cyc   = e;
        busy_from = e;        busy_to = e + NP + CD - 1;
        nmi_from  = e + 1;    nmi_to  = e + NP;
        rst_from  = NONE;     rst_to  = NONE;
        done_at   = e + NP;
        soft_last = e + NP;   // last edge at which a hard request still upgrades
    endtask

    // Hard sequence accepted at edge e; nmi_start carries over an upgraded soft pulse
    task automatic start_hard(input int e, input int nmi_start, input int bfrom);
        ack_cyc   = e;
        busy_from = bfrom;       busy_to = e + NR + RH + CD - 1;
        nmi_from  = nmi_start;   nmi_to  = e + NR + RH;
        rst_from  = e + NR + 1;  rst_to  = e + NR + RH;
        done_at   = e + NR + RH;
        soft_last = NONE;
    endtask

    // Apply the request rules to the inputs sampled at edge e
    task automatic model_edge(input int e, input logic s, input logic h, input logic x);
        if (e - 1 > busy_to) begin
            if (!x && h)      start_hard(e, e + 1, e);
            else if (!x && s) start_soft(e);
        end else if (e <= soft_last && h) begin
            start_hard(e, nmi_from, busy_from);
        end
    endtask

    function automatic logic in_win(input int k, input int lo, input int hi);
        return (k >= lo) && (k <= hi);
    endfunction

    task automatic check_all(input string ctx);
        check({ctx, ".req_ack"},  req_ack,  logic'(ack_cyc == cyc));
        check({ctx, ".busy"},     busy,     in_win(cyc, busy_from, busy_to));
        check({ctx, ".done"},     done,     logic'(done_at == cyc));
        check({ctx, ".nmi_oe"},   nmi_oe,   in_win(cyc, nmi_from, nmi_to));
        check({ctx, ".reset_oe"}, reset_oe, in_win(cyc, rst_from, rst_to));
    endtask

    // One clock: drive inputs, advance, predict, compare #1 after the edge
    task automatic step(input logic s, input logic h, input logic x, input string ctx);
        soft_req = s; hard_req = h; ext_hard_reset = x;
        @(posedge clk);
        cyc++;
        model_edge(cyc, s, h, x);
        #1;
        check_all(ctx);
    endtask

    task automatic idle(input int n, input string ctx);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, ctx);
    endtask

    initial begin
        model_clear();
        #1;
        check("reset.req_ack",  req_ack,  1'b0);
        check("reset.busy",     busy,     1'b0);
        check("reset.done",     done,     1'b0);
        check("reset.nmi_oe",   nmi_oe,   1'b0);
        check("reset.reset_oe", reset_oe, 1'b0);
        repeat (2) @(posedge clk);
        #5 reset_n = 1'b1;

        // Soft request alone
        step(1'b1, 1'b0, 1'b0, "soft");
        idle(10, "soft");
        // Simultaneous soft+hard resolves to hard
        step(1'b1, 1'b1, 1'b0, "both");
        idle(22, "both");
        // Soft, then hard two cycles later upgrades
        step(1'b1, 1'b0, 1'b0, "upg");
        step(1'b0, 1'b0, 1'b0, "upg");
        step(1'b0, 1'b1, 1'b0, "upg");
        idle(22, "upg");
        // Hard, then requests during HARD_RESET and COOLDOWN are dropped
        step(1'b0, 1'b1, 1'b0, "lock");
        idle(12, "lock");
        step(1'b0, 1'b1, 1'b0, "lock_hr");
        idle(3, "lock");
        step(1'b1, 1'b0, 1'b0, "lock_cd");
        idle(6, "lock");
        // External reset held in IDLE masks requests
        step(1'b1, 1'b0, 1'b1, "ext");
        step(1'b0, 1'b1, 1'b1, "ext");
        idle(2, "ext");

        // Async reset in the middle of HARD_RESET
        step(1'b0, 1'b1, 1'b0, "arst");
        begin
            int guard = 0;
            while (reset_oe !== 1'b1 && guard < 40) begin
                idle(1, "arst");
                guard++;
            end
            check("arst.reached_hard_reset", reset_oe, 1'b1);
        end
        idle(2, "arst");
        #2 reset_n = 1'b0;
        #1;
        check("arst.nmi_oe",   nmi_oe,   1'b0);
        check("arst.reset_oe", reset_oe, 1'b0);
        check("arst.busy",     busy,     1'b0);
        model_clear();
        @(posedge clk);
        #5 reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, "post_arst");
        idle(10, "post_arst");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic s, h, x;
            s = ($urandom_range(0, 7) == 0);
            h = ($urandom_range(0, 11) == 0);
            x = ($urandom_range(0, 9) == 0);
            step(s, h, x, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_n64_reset_driver
`default_nettype wire
